// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined RISC-V immediate generator:
// format codes, opcode constants and flow-control state encoding.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate decode: instruction word -> {imm, fmt, unknown}.
// Define IMM_GEN_CSR_EN to decode the CSR zimm field (format Z).
module imm_extract
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output fmt_e            fmt,
   output logic            unknown
);

   logic [31:0] imm32;

   always_comb begin
      fmt     = FMT_NONE;
      unknown = 1'b0;
      case (instr[6:0])
         OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
         OP_IMM32: begin
            if (XLEN == 64) fmt = FMT_I;
            else            unknown = 1'b1;
         end
         OP_STORE:         fmt = FMT_S;
         OP_BRANCH:        fmt = FMT_B;
         OP_LUI, OP_AUIPC: fmt = FMT_U;
         OP_JAL:           fmt = FMT_J;
         OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
            fmt = instr[14] ? FMT_Z : FMT_I;
`else
            fmt = FMT_I;
`endif
         end
         default:          unknown = 1'b1;
      endcase
   end

   // Build a 32-bit signed immediate, then widen; Z is the only zero-extended form.
   always_comb begin
      imm32 = '0;
      case (fmt)
         FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm32 = {instr[31:12], 12'b0};
         FMT_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      imm = XLEN'($signed(imm32));
      if (fmt == FMT_Z) imm = XLEN'(instr[19:15]);
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generator stage with valid/ready, skid register and
// saturating unknown-opcode counter. IMM_GEN_CSR_EN enables CSR zimm decode.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_unknown,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] unknown_cnt
);

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] imm;
      fmt_e            fmt;
      logic            unknown;
   } entry_t;

   state_e            state_reg, state_next;
   entry_t            out_reg, skid_reg, new_entry;
   logic [CNT_W-1:0]  cnt_reg;
   logic [XLEN-1:0]   ext_imm;
   fmt_e              ext_fmt;
   logic              ext_unknown;
   logic              in_xfer, out_xfer;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr   (in_instr),
      .imm     (ext_imm),
      .fmt     (ext_fmt),
      .unknown (ext_unknown)
   );

   assign new_entry = '{instr: in_instr, imm: ext_imm, fmt: ext_fmt, unknown: ext_unknown};
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_EMPTY;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_EMPTY: if (in_xfer) state_next = ST_FULL;
         ST_FULL: begin
            if (in_xfer && !out_xfer)      state_next = ST_SKID;
            else if (!in_xfer && out_xfer) state_next = ST_EMPTY;
         end
         ST_SKID:  if (out_xfer) state_next = ST_FULL;
         default:  state_next = ST_EMPTY;
      endcase
   end

   // Handshake outputs depend only on the state register, never on out_ready.
   always_comb begin
      in_ready  = (state_reg != ST_SKID);
      out_valid = (state_reg == ST_FULL) || (state_reg == ST_SKID);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg  <= '0;
         skid_reg <= '0;
      end else begin
         case (state_reg)
            ST_EMPTY: if (in_xfer) out_reg <= new_entry;
            ST_FULL: begin
               if (in_xfer && out_xfer)  out_reg  <= new_entry;
               if (in_xfer && !out_xfer) skid_reg <= new_entry;
            end
            ST_SKID:  if (out_xfer) out_reg <= skid_reg;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_reg <= '0;
      else if (cnt_clr)
         cnt_reg <= '0;
      else if (in_xfer && ext_unknown && (cnt_reg != {CNT_W{1'b1}}))
         cnt_reg <= cnt_reg + CNT_W'(1);
   end

   assign out_instr   = out_reg.instr;
   assign out_imm     = out_reg.imm;
   assign out_fmt     = out_reg.fmt;
   assign out_unknown = out_reg.unknown;
   assign unknown_cnt = cnt_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised bench for imm_gen_pipe: an XLEN=32/CNT_W=16 and an XLEN=64/CNT_W=2
// instance share stimulus and are checked against a FIFO + arithmetic reference.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic        out_ready = 1'b0;
   logic        cnt_clr = 1'b0;

   logic        a_in_ready, a_out_valid, a_out_unknown;
   logic [31:0] a_out_instr, a_out_imm;
   logic [2:0]  a_out_fmt;
   logic [15:0] a_cnt;
   logic        b_in_ready, b_out_valid, b_out_unknown;
   logic [31:0] b_out_instr;
   logic [63:0] b_out_imm;
   logic [2:0]  b_out_fmt;
   logic [1:0]  b_cnt;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] q[$];
   int cnt_a_m = 0;
   int cnt_b_m = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_instr(a_out_instr), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
      .out_unknown(a_out_unknown), .cnt_clr(cnt_clr), .unknown_cnt(a_cnt));

   imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_instr(b_out_instr), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
      .out_unknown(b_out_unknown), .cnt_clr(cnt_clr), .unknown_cnt(b_cnt));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference decode using shifts on the signed word rather than bit splicing.
   function automatic void ref_decode(input logic [31:0] ins, input bit is64,
                                      output logic [63:0] imm, output logic [2:0] fmt,
                                      output logic unk);
      logic signed [31:0] s;
      logic [31:0] v;
      s = ins;
      fmt = 3'd0; unk = 1'b0; v = '0;
      case (ins[6:0])
         7'b0000011, 7'b0010011, 7'b1100111: fmt = 3'd1;
         7'b0011011: if (is64) fmt = 3'd1; else unk = 1'b1;
         7'b0100011: fmt = 3'd2;
         7'b1100011: fmt = 3'd3;
         7'b0110111, 7'b0010111: fmt = 3'd4;
         7'b1101111: fmt = 3'd5;
`ifdef IMM_GEN_CSR_EN
         7'b1110011: fmt = ins[14] ? 3'd6 : 3'd1;
`else
         7'b1110011: fmt = 3'd1;
`endif
         default: unk = 1'b1;
      endcase
      case (fmt)
         3'd1: v = 32'(s >>> 20);
         3'd2: v = 32'((s >>> 25) << 5) | 32'(ins[11:7]);
         3'd3: v = 32'((s >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
         3'd4: v = ins & 32'hFFFF_F000;
         3'd5: v = 32'((s >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
         default: v = '0;
      endcase
      imm = {{32{v[31]}}, v};
      if (fmt == 3'd6) imm = 64'(ins[19:15]);
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [12];
      logic [31:0] r;
      ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011, 7'b0100011, 7'b1100011,
              7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b1111111, 7'b0000000};
      r = $urandom;
      if ($urandom_range(0, 5) == 0) return r;
      return {r[31:7], ops[$urandom_range(0, 11)]};
   endfunction

   // One clock: check outputs at negedge, drive inputs, then advance the model at posedge.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic clr);
      logic [63:0] ei; logic [2:0] ef; logic eu, ua, ub, in_x, out_x;
      @(negedge clk);
      check_eq("a_in_ready", a_in_ready, q.size() < 2);
      check_eq("b_in_ready", b_in_ready, q.size() < 2);
      check_eq("a_out_valid", a_out_valid, q.size() > 0);
      check_eq("b_out_valid", b_out_valid, q.size() > 0);
      if (q.size() > 0) begin
         ref_decode(q[0], 1'b0, ei, ef, eu);
         check_eq("a_out_instr", a_out_instr, q[0]);
         check_eq("a_out_imm", a_out_imm, ei[31:0]);
         check_eq("a_out_fmt", a_out_fmt, ef);
         check_eq("a_out_unknown", a_out_unknown, eu);
         ref_decode(q[0], 1'b1, ei, ef, eu);
         check_eq("b_out_instr", b_out_instr, q[0]);
         check_eq("b_out_imm", b_out_imm, ei);
         check_eq("b_out_fmt", b_out_fmt, ef);
         check_eq("b_out_unknown", b_out_unknown, eu);
      end
      check_eq("a_cnt", a_cnt, cnt_a_m);
      check_eq("b_cnt", b_cnt, cnt_b_m);
      in_valid = v; in_instr = ins; out_ready = ordy; cnt_clr = clr;
      in_x  = v && (q.size() < 2);
      out_x = ordy && (q.size() > 0);
      ref_decode(ins, 1'b0, ei, ef, ua);
      ref_decode(ins, 1'b1, ei, ef, ub);
      @(posedge clk);
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(ins);
      if (clr) begin cnt_a_m = 0; cnt_b_m = 0; end
      else if (in_x) begin
         if (ua && cnt_a_m < 65535) cnt_a_m++;
         if (ub && cnt_b_m < 3) cnt_b_m++;
      end
   endtask

   task automatic check_reset();
      check_eq("rst_a_in_ready", a_in_ready, 1);
      check_eq("rst_b_in_ready", b_in_ready, 1);
      check_eq("rst_a_out_valid", a_out_valid, 0);
      check_eq("rst_b_out_valid", b_out_valid, 0);
      check_eq("rst_a_out_instr", a_out_instr, 0);
      check_eq("rst_a_out_imm", a_out_imm, 0);
      check_eq("rst_b_out_imm", b_out_imm, 0);
      check_eq("rst_a_out_fmt", a_out_fmt, 0);
      check_eq("rst_a_out_unknown", a_out_unknown, 0);
      check_eq("rst_a_cnt", a_cnt, 0);
      check_eq("rst_b_cnt", b_cnt, 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
      #1 check_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      q.delete(); cnt_a_m = 0; cnt_b_m = 0;
   endtask

   initial begin
      #2 check_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;

      cycle(1, 32'hFFF0_0093, 1, 0);
      #1 check_eq("addi_imm", a_out_imm, 32'hFFFF_FFFF);
      check_eq("addi_fmt", a_out_fmt, 1);
      cycle(1, 32'h8000_00B7, 1, 0);
      #1 check_eq("lui_imm64", b_out_imm, 64'hFFFF_FFFF_8000_0000);
      check_eq("lui_fmt", b_out_fmt, 4);
      cycle(1, 32'hFE00_0EE3, 1, 0);
      #1 check_eq("beq_imm", a_out_imm, 32'hFFFF_FFFC);
      check_eq("beq_fmt", a_out_fmt, 3);
      cycle(1, 32'h0000_006F, 1, 0);
      #1 check_eq("jal_imm", a_out_imm, 0);
      check_eq("jal_fmt", a_out_fmt, 5);
      cycle(0, 0, 1, 0);

      cycle(1, 32'h0050_0113, 0, 0);
      cycle(1, 32'h0070_0193, 0, 0);
      #1 check_eq("bp_in_ready_low", a_in_ready, 0);
      check_eq("bp_hold_first", a_out_instr, 32'h0050_0113);
      cycle(0, 0, 0, 0);
      #1 check_eq("bp_still_first", a_out_instr, 32'h0050_0113);
      cycle(0, 0, 1, 0);
      #1 check_eq("bp_second", a_out_instr, 32'h0070_0193);
      check_eq("bp_in_ready_back", a_in_ready, 1);
      cycle(0, 0, 1, 0);

      cycle(0, 0, 1, 1);
      for (int i = 0; i < 3; i++) cycle(1, 32'h0000_007F, 1, 0);
      #1 check_eq("unk_cnt3_a", a_cnt, 3);
      check_eq("unk_cnt3_b", b_cnt, 3);
      check_eq("unk_flag", a_out_unknown, 1);
      check_eq("unk_imm", a_out_imm, 0);
      for (int i = 0; i < 3; i++) cycle(1, 32'h0000_007F, 1, 0);
      #1 check_eq("unk_cnt6_a", a_cnt, 6);
      check_eq("unk_sat_b", b_cnt, 3);
      cycle(1, 32'h0000_007F, 1, 1);
      #1 check_eq("clr_prio_a", a_cnt, 0);
      check_eq("clr_prio_b", b_cnt, 0);

      cycle(1, 32'h3400_D073, 1, 0);
`ifdef IMM_GEN_CSR_EN
      #1 check_eq("csr_fmt", a_out_fmt, 6);
      check_eq("csr_imm", a_out_imm, 1);
`else
      #1 check_eq("csr_fmt", a_out_fmt, 1);
      check_eq("csr_imm", a_out_imm, 32'h0000_0340);
`endif
      cycle(0, 0, 1, 0);

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            cycle(1, rand_instr(), 0, 0);
            cycle(1, rand_instr(), 0, 0);
            apply_reset();
         end
         cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
               $urandom_range(0, 40) == 0);
      end
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
